// File: rtl/gray_arb_pkg.sv
// gray_arb_pkg: shared constants and helpers for gray_conv_arbiter.
package gray_arb_pkg;
  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 4;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/gray_enc_core.sv
// gray_enc_core: combinational binary-to-Gray encoder.
module gray_enc_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);
  assign gray_o = bin_i ^ (bin_i >> 1);
endmodule

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin shared binary-to-Gray converter with a registered valid/ready output.
// Define GRAY_ARB_PARITY_EN to add out_par and the sticky chk_err round-trip check.
module gray_conv_arbiter
  import gray_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  localparam int ID_W = clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_gray,
  output logic [WIDTH-1:0]       out_bin,
  output logic [ID_W-1:0]        out_id,
  output logic [CNT_W-1:0]       grant_cnt
`ifdef GRAY_ARB_PARITY_EN
  ,
  output logic                   out_par,
  input  logic                   chk_err_clr,
  output logic                   chk_err
`endif
);
  logic                load, take, gnt_vld;
  logic [ID_W-1:0]     cand [N_REQ];
  logic [ID_W-1:0]     gnt_id, rr_ptr_q, rr_ptr_d, out_id_q, out_id_d;
  logic [WIDTH-1:0]    win_data, win_gray, out_bin_q, out_bin_d, out_gray_q, out_gray_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    grant_cnt_q, grant_cnt_d;

  // Scan from the highest offset down so the closest requester to rr_ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id = '0;
    for (int k = 0; k < N_REQ; k++) cand[k] = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_valid[cand[k]]) begin
        gnt_vld = 1'b1;
        gnt_id = cand[k];
      end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt_id == ID_W'(i)) win_data = req_data[i*WIDTH +: WIDTH];
  end

  gray_enc_core #(.WIDTH(WIDTH)) u_enc (.bin_i(win_data), .gray_o(win_gray));

  always_comb begin
    load = !out_valid_q || out_ready;
    take = load && gnt_vld;
    for (int i = 0; i < N_REQ; i++) req_ready[i] = rst_n && take && gnt_id == ID_W'(i);
    out_valid_d = load ? gnt_vld : out_valid_q;
    out_bin_d = take ? win_data : out_bin_q;
    out_gray_d = take ? win_gray : out_gray_q;
    out_id_d = take ? gnt_id : out_id_q;
    rr_ptr_d = !take ? rr_ptr_q : (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
    grant_cnt_d = (take && grant_cnt_q != CNT_SAT) ? grant_cnt_q + 1'b1 : grant_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_bin_q <= '0;
      out_gray_q <= '0;
      out_id_q <= '0;
      rr_ptr_q <= '0;
      grant_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_bin_q <= out_bin_d;
      out_gray_q <= out_gray_d;
      out_id_q <= out_id_d;
      rr_ptr_q <= rr_ptr_d;
      grant_cnt_q <= grant_cnt_d;
    end

  assign out_valid = out_valid_q;
  assign out_bin = out_bin_q;
  assign out_gray = out_gray_q;
  assign out_id = out_id_q;
  assign grant_cnt = grant_cnt_q;

`ifdef GRAY_ARB_PARITY_EN
  logic             out_par_q, out_par_d, chk_err_q, chk_err_d;
  logic [WIDTH-1:0] chk_gray;

  // Gray coding is a bijection, so re-encoding out_bin and comparing to out_gray
  // flags exactly the cases where decoding out_gray would disagree with out_bin.
  gray_enc_core #(.WIDTH(WIDTH)) u_chk (.bin_i(out_bin_q), .gray_o(chk_gray));

  always_comb begin
    out_par_d = take ? ^win_gray : out_par_q;
    chk_err_d = (out_valid_q && chk_gray != out_gray_q) ? 1'b1 : chk_err_clr ? 1'b0 : chk_err_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_par_q <= 1'b0;
      chk_err_q <= 1'b0;
    end else begin
      out_par_q <= out_par_d;
      chk_err_q <= chk_err_d;
    end

  assign out_par = out_par_q;
  assign chk_err = chk_err_q;
`endif
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb_gray_conv_arbiter: directed scoreboard bench for gray_conv_arbiter (N_REQ=4, WIDTH=4).
module tb_gray_conv_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid, out_ready;
  logic [3:0]  out_gray, out_bin;
  logic [1:0]  out_id;
  logic [15:0] grant_cnt;
`ifdef GRAY_ARB_PARITY_EN
  logic        out_par, chk_err_clr, chk_err;
`endif

  typedef struct {
    logic [1:0] id;
    logic [3:0] bin;
    logic [3:0] gray;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  bit         sweep = 0;
  bit         have_prev = 0;
  logic [3:0] prev_gray;
  logic [3:0] gtab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                            4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  gray_conv_arbiter #(.N_REQ(4), .WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_gray(out_gray), .out_bin(out_bin), .out_id(out_id), .grant_cnt(grant_cnt)
`ifdef GRAY_ARB_PARITY_EN
    , .out_par(out_par), .chk_err_clr(chk_err_clr), .chk_err(chk_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [3:0] bin, input logic [3:0] gray);
    exp_t e;
    e.id = id;
    e.bin = bin;
    e.gray = gray;
    exp_q.push_back(e);
  endtask

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_xfer", {22'd0, out_id, out_bin, out_gray}, 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("xfer", {22'd0, out_id, out_bin, out_gray}, {22'd0, e.id, e.bin, e.gray});
`ifdef GRAY_ARB_PARITY_EN
        chk("out_par", {31'd0, out_par}, {31'd0, ^e.gray});
        chk("chk_err", {31'd0, chk_err}, 32'd0);
`endif
        if (sweep) begin
          if (have_prev) chk("adjacent_one_bit", $countones(out_gray ^ prev_gray), 32'd1);
          prev_gray = out_gray;
          have_prev = 1'b1;
        end
      end
    end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef GRAY_ARB_PARITY_EN
    chk_err_clr = 1'b0;
`endif
    rst_n = 1'b0;
    out_ready = 1'b1;
    req_valid = 4'b1111;
    req_data = {4'hF, 4'hA, 4'h5, 4'h0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_grant_cnt", grant_cnt, 16'd0);
    chk("rst_out_gray", out_gray, 4'd0);
    chk("rst_out_id", out_id, 2'd0);
    cyc();
    rst_n = 1'b1;
    push(2'd0, 4'b0000, 4'b0000);
    push(2'd1, 4'b0101, 4'b0111);
    push(2'd2, 4'b1010, 4'b1111);
    push(2'd3, 4'b1111, 4'b1000);
    push(2'd0, 4'b0000, 4'b0000);
    @(negedge clk);
    chk("first_ready", req_ready, 4'b0001);
    repeat (5) @(posedge clk);
    #1 req_valid = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("grant_cnt_5", grant_cnt, 16'd5);

    cyc();
    req_valid = 4'b0100;
    req_data[8 +: 4] = 4'b0110;
    push(2'd2, 4'b0110, 4'b0101);
    @(negedge clk);
    chk("only_req2_ready", req_ready, 4'b0100);
    cyc();
    req_valid = 4'b1010;
    req_data[4 +: 4] = 4'b0011;
    req_data[12 +: 4] = 4'b1001;
    push(2'd3, 4'b1001, 4'b1101);
    push(2'd1, 4'b0011, 4'b0010);
    @(negedge clk);
    chk("rr_req3_first", req_ready, 4'b1000);
    cyc();
    req_valid = 4'b0010;
    @(negedge clk);
    chk("rr_req1_next", req_ready, 4'b0010);
    cyc();
    req_valid = 4'b0000;
    cyc();

    out_ready = 1'b0;
    req_valid = 4'b0001;
    req_data[0 +: 4] = 4'b1100;
    push(2'd0, 4'b1100, 4'b1010);
    push(2'd3, 4'b0111, 4'b0100);
    push(2'd0, 4'b0001, 4'b0001);
    @(negedge clk);
    chk("stall_pre_ready", req_ready, 4'b0001);
    cyc();
    req_valid = 4'b1001;
    req_data[0 +: 4] = 4'b0001;
    req_data[12 +: 4] = 4'b0111;
    repeat (5) begin
      @(negedge clk);
      chk("stall_req_ready", req_ready, 4'b0000);
      chk("stall_hold", {out_valid, out_id, out_bin, out_gray}, {1'b1, 2'd0, 4'b1100, 4'b1010});
    end
    cyc();
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_ready", req_ready, 4'b1000);
    cyc();
    req_valid = 4'b0001;
    cyc();
    req_valid = 4'b0000;
    cyc();

    sweep = 1'b1;
    for (int b = 0; b < 16; b++) begin
      req_data[4 +: 4] = 4'(b);
      req_valid = 4'b0010;
      push(2'd1, 4'(b), gtab[b]);
      cyc();
    end
    req_valid = 4'b0000;
    repeat (2) cyc();
    sweep = 1'b0;

    out_ready = 1'b0;
    req_valid = 4'b0100;
    req_data[8 +: 4] = 4'b0101;
    cyc();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("stall_before_reset", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    req_valid = 4'b0110;
    #1;
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_req_ready", req_ready, 4'b0000);
    chk("async_rst_grant_cnt", grant_cnt, 16'd0);
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    push(2'd1, 4'b1111, 4'b1000);
    push(2'd2, 4'b0101, 4'b0111);
    @(negedge clk);
    chk("post_rst_ready", req_ready, 4'b0010);
    cyc();
    req_valid = 4'b0100;
    cyc();
    req_valid = 4'b0000;

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
